// File: rtl/fifo_stream_adapter.sv
// Read-side adapter behind synchronous_fifo: paces r_en, absorbs the one-cycle read latency
// in a 2-entry buffer and presents a valid/ready stream. Optional counter: FIFO_STREAM_CNT_EN.
module fifo_stream_adapter #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_r_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_STREAM_CNT_EN
   ,
   output logic [15:0]           m_count
`endif
);

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_TWO   = 2'd2;

   logic [1:0]            occ;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] head_q;
   logic [DATA_WIDTH-1:0] tail_q;
   logic                  pop;
   logic [2:0]            load;

   assign pop  = m_valid && m_ready;
   assign load = {1'b0, occ} + {2'b00, inflight};

   // A pop this cycle frees a slot, so it counts as credit for a new read (no bubble on release).
   assign fifo_r_en = !rst && !fifo_empty && (load < (3'd2 + {2'b00, pop}));

   assign m_valid = (occ != OCC_EMPTY);
   assign m_data  = head_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         occ      <= OCC_EMPTY;
         inflight <= 1'b0;
         head_q   <= '0;
         tail_q   <= '0;
      end else begin
         inflight <= fifo_r_en && !fifo_empty;
         case (occ)
            OCC_EMPTY: begin
               if (inflight) begin
                  head_q <= fifo_data_out;
                  occ    <= OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (inflight && pop) begin
                  head_q <= fifo_data_out;
               end else if (inflight) begin
                  tail_q <= fifo_data_out;
                  occ    <= OCC_TWO;
               end else if (pop) begin
                  occ    <= OCC_EMPTY;
               end
            end
            OCC_TWO: begin
               // Pacing never issues a capture into TWO unless a pop makes room.
               if (pop) begin
                  head_q <= tail_q;
                  if (inflight) tail_q <= fifo_data_out;
                  else          occ    <= OCC_ONE;
               end
            end
            default: occ <= OCC_EMPTY;
         endcase
      end
   end

`ifdef FIFO_STREAM_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)      m_count <= 16'h0000;
      else if (pop) m_count <= m_count + 16'h0001;
   end
`endif

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: behavioural FIFO + ordered-word reference, randomized traffic.
module tb_fifo_stream_adapter;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_data_out = '0;
   logic          fifo_r_en;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
`ifdef FIFO_STREAM_CNT_EN
   logic [15:0]   m_count;
`endif

   fifo_stream_adapter #(.DATA_WIDTH(DW)) dut (
      .clk           (clk),
      .rst           (rst),
      .fifo_empty    (fifo_empty),
      .fifo_data_out (fifo_data_out),
      .fifo_r_en     (fifo_r_en),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data)
`ifdef FIFO_STREAM_CNT_EN
      ,
      .m_count       (m_count)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Words offered to the FIFO, in order (owned by the stimulus side).
   logic [DW-1:0] pend_mem [0:1023];
   int            pend_wr = 0;
   logic          fifo_flush = 1'b0;

   // Environment side: FIFO contents, delivered words, occupancy bookkeeping.
   logic [DW-1:0] fq [$];
   logic [DW-1:0] got_mem [0:1023];
   int            got_cnt = 0;
   int            pend_rd = 0;
   int            rd_cnt = 0;
   int            out_cnt = 0;
   int            max_out = 0;
   int            viol_rst = 0;
   int            viol_empty = 0;

   always begin
      @(posedge clk);
      if (rst && fifo_r_en) viol_rst++;
      if (fifo_r_en && fifo_empty) viol_empty++;
      if (!rst && m_valid && m_ready) begin
         got_mem[got_cnt] = m_data;
         got_cnt++;
         out_cnt--;
      end
      if (fifo_r_en && !fifo_empty && fq.size() != 0) begin
         fifo_data_out <= fq.pop_front();
         rd_cnt++;
         out_cnt++;
      end
      if (rst) out_cnt = 0;
      if (out_cnt > max_out) max_out = out_cnt;
      if (fifo_flush) begin
         fq.delete();
         pend_rd = pend_wr;
      end
      while (pend_rd < pend_wr) begin
         fq.push_back(pend_mem[pend_rd]);
         pend_rd++;
      end
      fifo_empty <= (fq.size() == 0);
   end

   task automatic push_word(input logic [DW-1:0] w);
      pend_mem[pend_wr] = w;
      pend_wr++;
   endtask

   task automatic wait_delivered(input int gb, input int n, input int budget);
      int k;
      k = 0;
      while ((got_cnt - gb) < n && k < budget) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic test_reset();
      int gb, pb;
      gb = got_cnt; pb = pend_wr;
      @(negedge clk);
      push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++;
         if (fifo_r_en !== 1'b0) begin n_bad++; $display("FAIL reset_r_en: got %b want 0", fifo_r_en); end
         n_cmp++;
         if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", m_valid); end
         n_cmp++;
         if (m_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", m_data); end
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (fifo_r_en !== 1'b1) begin n_bad++; $display("FAIL reset_first_r_en: got %b want 1", fifo_r_en); end
      m_ready = 1'b1;
      wait_delivered(gb, 3, 20);
      n_cmp++;
      if (got_cnt - gb != 3) begin n_bad++; $display("FAIL reset_drain_count: got %0d want 3", got_cnt - gb); end
      for (int i = 0; i < 3 && i < got_cnt - gb; i++) begin
         n_cmp++;
         if (got_mem[gb+i] !== pend_mem[pb+i])
            begin n_bad++; $display("FAIL reset_drain_word%0d: got %h want %h", i, got_mem[gb+i], pend_mem[pb+i]); end
      end
      m_ready = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_streaming();
      m_ready = 1'b1;
      @(negedge clk);
      for (int i = 1; i <= 8; i++) push_word(DW'(i));
      @(negedge clk);
      n_cmp++;
      if (fifo_r_en !== 1'b1 || m_valid !== 1'b0)
         begin n_bad++; $display("FAIL stream_first_cycle: r_en %b valid %b want 1 0", fifo_r_en, m_valid); end
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b0) begin n_bad++; $display("FAIL stream_latency: valid %b want 0", m_valid); end
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         n_cmp++;
         if (m_valid !== 1'b1 || m_data !== DW'(i))
            begin n_bad++; $display("FAIL stream_word%0d: valid %b data %h want 1 %h", i, m_valid, m_data, DW'(i)); end
      end
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b0) begin n_bad++; $display("FAIL stream_end: valid %b want 0", m_valid); end
      m_ready = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_backpressure();
      int rd0;
      m_ready = 1'b0;
      @(negedge clk);
      rd0 = rd_cnt;
      for (int i = 0; i < 8; i++) push_word(DW'(8'h10 + i));
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i >= 1) begin
            n_cmp++;
            if (m_valid !== 1'b1 || m_data !== 8'h10)
               begin n_bad++; $display("FAIL bp_hold%0d: valid %b data %h want 1 10", i, m_valid, m_data); end
         end
      end
      n_cmp++;
      if (rd_cnt - rd0 != 2) begin n_bad++; $display("FAIL bp_reads: got %0d want 2", rd_cnt - rd0); end
      m_ready = 1'b1;
      #1;
      n_cmp++;
      if (fifo_r_en !== 1'b1) begin n_bad++; $display("FAIL bp_pop_credit: r_en %b want 1", fifo_r_en); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (m_valid !== 1'b1 || m_data !== DW'(8'h10 + i))
            begin n_bad++; $display("FAIL bp_release%0d: valid %b data %h want 1 %h", i, m_valid, m_data, DW'(8'h10 + i)); end
         @(negedge clk);
      end
      n_cmp++;
      if (m_valid !== 1'b0) begin n_bad++; $display("FAIL bp_end: valid %b want 0", m_valid); end
      m_ready = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_alternating();
      int gb, pb, k;
      gb = got_cnt; pb = pend_wr;
      @(negedge clk);
      for (int i = 0; i < 8; i++) push_word(DW'($urandom_range(0, 255)));
      m_ready = 1'b1;
      k = 0;
      while ((got_cnt - gb) < 8 && k < 60) begin
         @(negedge clk);
         m_ready = ~m_ready;
         k++;
      end
      n_cmp++;
      if (got_cnt - gb != 8) begin n_bad++; $display("FAIL alt_count: got %0d want 8", got_cnt - gb); end
      for (int i = 0; i < 8 && i < got_cnt - gb; i++) begin
         n_cmp++;
         if (got_mem[gb+i] !== pend_mem[pb+i])
            begin n_bad++; $display("FAIL alt_word%0d: got %h want %h", i, got_mem[gb+i], pend_mem[pb+i]); end
      end
      n_cmp++;
      if (max_out > 2) begin n_bad++; $display("FAIL alt_occupancy: got %0d want <=2", max_out); end
      m_ready = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_random();
      int gb, pb, n;
      gb = got_cnt; pb = pend_wr;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 9) < 4 && (pend_wr - pb) < 120) push_word(DW'($urandom));
         m_ready = ($urandom_range(0, 3) != 0);
      end
      m_ready = 1'b1;
      n = pend_wr - pb;
      wait_delivered(gb, n, 300);
      n_cmp++;
      if (got_cnt - gb != n) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", got_cnt - gb, n); end
      for (int i = 0; i < n && i < got_cnt - gb; i++) begin
         n_cmp++;
         if (got_mem[gb+i] !== pend_mem[pb+i])
            begin n_bad++; $display("FAIL rand_word%0d: got %h want %h", i, got_mem[gb+i], pend_mem[pb+i]); end
      end
      n_cmp++;
      if (max_out > 2) begin n_bad++; $display("FAIL rand_occupancy: got %0d want <=2", max_out); end
      n_cmp++;
      if (viol_empty != 0) begin n_bad++; $display("FAIL rand_underflow: got %0d want 0", viol_empty); end
      m_ready = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_midflight();
      int rd0, gb;
      m_ready = 1'b0;
      @(negedge clk);
      gb = got_cnt;
      push_word(8'hC1); push_word(8'hC2); push_word(8'hC3);
      @(negedge clk);
      rd0 = rd_cnt;
      @(negedge clk);
      n_cmp++;
      if (rd_cnt - rd0 != 1) begin n_bad++; $display("FAIL mid_read: got %0d want 1", rd_cnt - rd0); end
      rst = 1'b1;
      fifo_flush = 1'b1;
      #1;
      n_cmp++;
      if (fifo_r_en !== 1'b0) begin n_bad++; $display("FAIL mid_r_en_rst: got %b want 0", fifo_r_en); end
      @(negedge clk);
      fifo_flush = 1'b0;
      n_cmp++;
      if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", m_valid); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mid_discard: got %b want 0", m_valid); end
      n_cmp++;
      if (got_cnt != gb) begin n_bad++; $display("FAIL mid_delivered: got %0d want 0", got_cnt - gb); end
      n_cmp++;
      if (viol_rst != 0) begin n_bad++; $display("FAIL mid_r_en_during_rst: got %0d want 0", viol_rst); end
      repeat (2) @(negedge clk);
   endtask

`ifdef FIFO_STREAM_CNT_EN
   task automatic test_counter();
      logic [15:0] want [0:2];
      want[0] = 16'hFFFF; want[1] = 16'h0000; want[2] = 16'h0001;
      m_ready = 1'b0;
      @(negedge clk);
      push_word(8'hD1); push_word(8'hD2); push_word(8'hD3);
      repeat (4) @(negedge clk);
      force dut.m_count = 16'hFFFE;
      #1;
      release dut.m_count;
      n_cmp++;
      if (m_count !== 16'hFFFE) begin n_bad++; $display("FAIL cnt_preload: got %h want fffe", m_count); end
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (m_count !== want[i]) begin n_bad++; $display("FAIL cnt_step%0d: got %h want %h", i, m_count, want[i]); end
      end
      m_ready = 1'b0;
      repeat (2) @(negedge clk);
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      m_ready = 1'b0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_alternating();
      test_random();
      test_reset_midflight();
`ifdef FIFO_STREAM_CNT_EN
      test_counter();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
